// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, owner codes, mem_writeEn codes.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      ERR   = 2'd3
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   // mem_writeEn from control: bit 1 requests an access, bit 0 selects write
   localparam logic [1:0] MEMOP_NONE = 2'b00;
   localparam logic [1:0] MEMOP_RD   = 2'b10;
   localparam logic [1:0] MEMOP_WR   = 2'b11;

   function automatic logic memop_is_wr(input logic [1:0] op);
      return op == MEMOP_WR;
   endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Busy-cycle watchdog: clearable, enabled counter with terminal count at TIMEOUT-1.
module mem_arb_wdog #(
   parameter int TIMEOUT = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + CW'(1);
   end

   assign tc = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store onto one variable-latency memory, one access at a time.
// Define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests instead of D-first.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int TIMEOUT = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_rdata,
   output logic          i_done,
   output logic          i_stall,
   input  logic [1:0]    d_op,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_done,
   output logic          d_stall,
   output logic          mem_en,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_done,
   output logic          err
);

   state_t        state, state_nxt;
   owner_t        owner;
   logic          d_req, win_d, grant, unaligned, issue, complete, wdog_tc;
   logic [AW-1:0] win_addr;

   assign d_req = d_op[1];

`ifdef ARB_ROUND_ROBIN_EN
   owner_t last_owner;

   assign win_d = d_req & (~i_req | (last_owner == OWN_I));

   always_ff @(posedge clk) begin
      if (rst)
         last_owner <= OWN_I;
      else if (grant)
         last_owner <= win_d ? OWN_D : OWN_I;
   end
`else
   assign win_d = d_req;
`endif

   // No grant in the cycle a done pulse is out: the requester still holds its request then
   assign grant     = (state == IDLE) & ~i_done & ~d_done & (d_req | i_req);
   assign win_addr  = win_d ? d_addr : i_addr;
   assign unaligned = win_addr[0];
   assign issue     = grant & ~unaligned;
   assign complete  = (state == BUSY) & mem_done;

   assign i_stall = i_req & ~i_done;
   assign d_stall = d_req & ~d_done;

   mem_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk (clk),
      .rst (rst),
      .clr (state == ISSUE),
      .en  (state == BUSY),
      .tc  (wdog_tc)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant) state_nxt = unaligned ? ERR : ISSUE;
         ISSUE:   state_nxt = BUSY;
         BUSY:    if (mem_done) state_nxt = IDLE;
                  else if (wdog_tc) state_nxt = ERR;
         default: state_nxt = ERR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= OWN_I;
         i_rdata   <= '0;
         d_rdata   <= '0;
         i_done    <= 1'b0;
         d_done    <= 1'b0;
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         err       <= 1'b0;
      end else begin
         state  <= state_nxt;
         mem_en <= issue;
         i_done <= complete & (owner == OWN_I);
         d_done <= complete & (owner == OWN_D);
         err    <= err | (state_nxt == ERR);
         if (issue) begin
            mem_addr <= win_addr;
            mem_wr   <= win_d & memop_is_wr(d_op);
            owner    <= win_d ? OWN_D : OWN_I;
            if (win_d)
               mem_wdata <= d_wdata;
         end
         if (complete) begin
            if (owner == OWN_I)
               i_rdata <= mem_rdata;
            else if (!mem_wr)
               d_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected commands and completions queued at stimulus time.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic [15:0] i_addr = '0;
   logic [15:0] i_rdata;
   logic        i_done, i_stall;
   logic [1:0]  d_op = MEMOP_NONE;
   logic [15:0] d_addr = '0;
   logic [15:0] d_wdata = '0;
   logic [15:0] d_rdata;
   logic        d_done, d_stall;
   logic        mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        mem_done = 1'b0;
   logic        err;

   typedef struct {
      logic [15:0] addr;
      logic        wr;
      logic [15:0] wdata;
      logic [15:0] rdata;
   } cmd_t;

   typedef struct {
      bit          is_d;
      logic [15:0] data;
   } exp_t;

   cmd_t        cmd_q[$];
   exp_t        sb_q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          mem_lat = 1;
   bit          hang = 1'b0;
   int          late_req = 0;
   logic [15:0] last_d = '0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(32)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
      .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
      .d_stall(d_stall),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory model: checks each command against the queue, answers after mem_lat cycles
   initial begin
      int   cnt;
      int   late_ack;
      cmd_t c;
      cnt = 0;
      late_ack = 0;
      c = '{16'h0, 1'b0, 16'h0, 16'h0};
      forever begin
         @(negedge clk);
         mem_done = 1'b0;
         if (late_req != late_ack) begin
            late_ack  = late_req;
            mem_done  = 1'b1;
            mem_rdata = 16'hDEAD;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               mem_done  = 1'b1;
               mem_rdata = c.rdata;
            end
         end
         if (mem_en) begin
            if (cmd_q.size() == 0) begin
               chk("cmd_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
               c = cmd_q.pop_front();
               chk("cmd_addr", 32'(mem_addr), 32'(c.addr));
               chk("cmd_wr", 32'(mem_wr), 32'(c.wr));
               if (c.wr) chk("cmd_wdata", 32'(mem_wdata), 32'(c.wdata));
               if (!hang) cnt = mem_lat;
            end
         end
      end
   end

   // Completion monitor: pops the scoreboard on every done pulse
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (i_done || d_done) begin
            if (sb_q.size() == 0) begin
               chk("done_unexpected", {30'd0, d_done, i_done}, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("done_side", {30'd0, d_done, i_done}, e.is_d ? 32'd2 : 32'd1);
               if (e.is_d) chk("d_rdata", 32'(d_rdata), 32'(e.data));
               else        chk("i_rdata", 32'(i_rdata), 32'(e.data));
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      i_req = 1'b0;
      d_op = MEMOP_NONE;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      last_d = '0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_i_rdata"}, 32'(i_rdata), 32'd0);
      chk({tag, "_d_rdata"}, 32'(d_rdata), 32'd0);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
      chk({tag, "_strobes"}, {27'd0, i_done, d_done, mem_en, mem_wr, err}, 32'd0);
   endtask

   task automatic wait_done(input bit is_d, input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(is_d ? d_done : i_done) && n < 200);
      if (n >= 200) chk({tag, "_timeout"}, 32'(n), 32'd199);
   endtask

   task automatic push_rd(input bit is_d, input logic [15:0] addr, input logic [15:0] data);
      cmd_q.push_back('{addr, 1'b0, 16'h0, data});
      sb_q.push_back('{is_d, data});
      if (is_d) last_d = data;
   endtask

   task automatic i_access(input logic [15:0] addr, input logic [15:0] data, input string tag);
      i_addr = addr;
      i_req  = 1'b1;
      push_rd(1'b0, addr, data);
      wait_done(1'b0, tag);
      i_req = 1'b0;
   endtask

   task automatic d_access(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] rdata, input string tag);
      d_addr  = addr;
      d_wdata = wdata;
      d_op    = wr ? MEMOP_WR : MEMOP_RD;
      if (wr) begin
         cmd_q.push_back('{addr, 1'b1, wdata, rdata});
         sb_q.push_back('{1'b1, last_d});
      end else begin
         push_rd(1'b1, addr, rdata);
      end
      wait_done(1'b1, tag);
      d_op = MEMOP_NONE;
   endtask

   initial begin
      bit d_first;
      do_reset();
      @(negedge clk);
      chk_reset("rst0");

      // fetch read, 1-cycle memory: exact latency
      i_addr = 16'h0010;
      i_req  = 1'b1;
      push_rd(1'b0, 16'h0010, 16'hBEEF);
      @(negedge clk);
      chk("t1_men_n1", 32'(mem_en), 32'd1);
      @(negedge clk);
      chk("t1_men_n2", 32'(mem_en), 32'd0);
      chk("t1_istall", 32'(i_stall), 32'd1);
      @(negedge clk);
      chk("t1_idone_n3", 32'(i_done), 32'd1);
      chk("t1_istall_done", 32'(i_stall), 32'd0);
      i_req = 1'b0;
      @(negedge clk);
      chk("t1_idone_pulse", 32'(i_done), 32'd0);

      // simultaneous: D wins, then one bubble before I is issued
      d_addr = 16'h0020;
      d_op   = MEMOP_RD;
      i_addr = 16'h0030;
      i_req  = 1'b1;
      push_rd(1'b1, 16'h0020, 16'h2222);
      push_rd(1'b0, 16'h0030, 16'h3333);
      wait_done(1'b1, "t2_d");
      d_op = MEMOP_NONE;
      @(negedge clk);
      chk("t2_bubble", 32'(mem_en), 32'd0);
      @(negedge clk);
      chk("t2_i_issue", 32'(mem_en), 32'd1);
      wait_done(1'b0, "t2_i");
      i_req = 1'b0;

      // prior D grant, then simultaneous requests
      d_access(1'b0, 16'h0022, 16'h4444, 16'h0, "t2b_pre");
`ifdef ARB_ROUND_ROBIN_EN
      d_first = 1'b0;
`else
      d_first = 1'b1;
`endif
      d_addr = 16'h0024;
      d_op   = MEMOP_RD;
      i_addr = 16'h0034;
      i_req  = 1'b1;
      if (d_first) begin
         push_rd(1'b1, 16'h0024, 16'h5555);
         push_rd(1'b0, 16'h0034, 16'h6666);
      end else begin
         push_rd(1'b0, 16'h0034, 16'h6666);
         push_rd(1'b1, 16'h0024, 16'h5555);
      end
      wait_done(d_first, "t2b_first");
      if (d_first) d_op = MEMOP_NONE; else i_req = 1'b0;
      wait_done(!d_first, "t2b_second");
      d_op  = MEMOP_NONE;
      i_req = 1'b0;

      // store with slower memory: d_rdata must keep the last load value
      mem_lat = 3;
      d_access(1'b1, 16'h0040, 16'h1234, 16'hFFFF, "t3_wr");
      mem_lat = 1;
      d_access(1'b0, 16'h0042, 16'h0000, 16'h7A7A, "t3_rd");

      // unaligned D read: err next cycle, nothing issued
      @(negedge clk);
      d_addr = 16'h0041;
      d_op   = MEMOP_RD;
      @(negedge clk);
      chk("t4_err", 32'(err), 32'd1);
      chk("t4_no_men", 32'(mem_en), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t4_hold", {29'd0, err, mem_en, d_done}, 32'd4);
      end
      chk("t4_dstall", 32'(d_stall), 32'd1);
      do_reset();
      chk("t4_err_clr", 32'(err), 32'd0);

      // hung memory: err after exactly 32 BUSY cycles
      hang   = 1'b1;
      i_addr = 16'h0050;
      i_req  = 1'b1;
      cmd_q.push_back('{16'h0050, 1'b0, 16'h0, 16'h0});
      repeat (33) @(negedge clk);
      chk("t5_err_early", 32'(err), 32'd0);
      @(negedge clk);
      chk("t5_err", 32'(err), 32'd1);
      chk("t5_istall", 32'(i_stall), 32'd1);
      do_reset();
      hang = 1'b0;
      i_access(16'h0070, 16'h7777, "t5_recover");

      // reset mid-access, then a stray late mem_done
      hang   = 1'b1;
      i_addr = 16'h0060;
      i_req  = 1'b1;
      cmd_q.push_back('{16'h0060, 1'b0, 16'h0, 16'h0});
      repeat (3) @(negedge clk);
      rst   = 1'b1;
      i_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      late_req++;
      repeat (3) @(negedge clk);
      chk_reset("t6");
      hang = 1'b0;

      chk("sb_left", 32'(sb_q.size()), 32'd0);
      chk("cmd_left", 32'(cmd_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
